// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: FSM encoding and default widths.
// No logic lives here.
package pc_sequencer_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OFF_W   = 8;
  localparam int RETIRE_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: pc + sext(offset) for a taken branch, otherwise pc + 1.
// Purely combinational, zero latency; wraps modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic              zero,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] incr;

  assign off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign incr     = (jump && zero) ? off_sext : {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pc_next  = pc + incr;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the PC: FETCH holds imem_req until ack, the instruction is presented
// the cycle after ack and held until exec_done; start=0 aborts to IDLE from any state.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                OFF_W    = DEF_OFF_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                jump,
  input  logic                zero,
  input  logic [OFF_W-1:0]    offset,
  input  logic                halt,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_t            state;
  logic [ADDR_W-1:0] pc_nxt;

  pc_next_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next (
    .pc      (pc),
    .jump    (jump),
    .zero    (zero),
    .offset  (offset),
    .pc_next (pc_nxt)
  );

  // Decoded straight from state so an async reset drops the request immediately.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      retire_cnt  <= '0;
    end else if (!start) begin
      // Abort beats any ack/exec_done in flight; the retire count survives.
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            retire_cnt  <= retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
            instr_valid <= 1'b0;
            if (halt) begin
              state <= ST_HALT;
            end else begin
              pc    <= pc_nxt;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: bench plays instruction memory and datapath, and compares against a
// transaction-level model of fetch addresses and retire count.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_ack, exec_done, jump, zero, halt;
  logic [15:0] imem_data;
  logic [7:0]  offset;
  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, instr, pc, retire_cnt;

  int          checks   = 0;
  int          failures = 0;
  int unsigned mpc      = 0;
  int unsigned mret     = 0;
  logic [15:0] cur_instr;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .jump        (jump),
    .zero        (zero),
    .offset      (offset),
    .halt        (halt),
    .pc          (pc),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference next-PC rule in plain integer arithmetic.
  function automatic int unsigned model_next(int unsigned p, bit j, bit z, logic [7:0] off);
    int signed soff;
    soff = int'($signed(off));
    if (j && z) return (p + soff) & 32'hFFFF;
    return (p + 1) & 32'hFFFF;
  endfunction

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
  endtask

  // Serve one fetch after lat wait cycles; stray exec_done meanwhile must be ignored.
  task automatic fetch(input string tag, input logic [15:0] data, input int lat);
    wait_req(tag);
    chk({tag, "_addr"}, {16'd0, imem_addr}, mpc);
    for (int i = 0; i < lat; i++) begin
      exec_done = 1'b1; halt = 1'b1; jump = 1'b1; zero = 1'b1;
      @(negedge clk);
      chk({tag, "_reqhold"}, {31'd0, imem_req}, 32'd1);
    end
    exec_done = 1'b0; halt = 1'b0; jump = 1'b0; zero = 1'b0;
    imem_ack  = 1'b1; imem_data = data;
    @(negedge clk);
    imem_ack  = 1'b0; imem_data = 16'($urandom);
    cur_instr = data;
    chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, {16'd0, instr}, {16'd0, data});
    chk({tag, "_reqoff"}, {31'd0, imem_req}, 32'd0);
  endtask

  // Hold exec for lat cycles (stray acks ignored), then complete it.
  task automatic exec(input string tag, input bit j, input bit z, input logic [7:0] off,
                      input bit h, input int lat);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b1; imem_data = 16'($urandom);
      @(negedge clk);
      chk({tag, "_vldhold"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_stable"},  {16'd0, instr}, {16'd0, cur_instr});
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1; jump = j; zero = z; offset = off; halt = h;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; zero = 1'b0; halt = 1'b0;
    mret = (mret + 1) & 32'hFFFF;
    chk({tag, "_vldclr"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_retire"}, {16'd0, retire_cnt}, mret);
    if (h) begin
      chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
      chk({tag, "_noreq"},  {31'd0, imem_req}, 32'd0);
      chk({tag, "_pcfrz"},  {16'd0, pc}, mpc);
    end else begin
      mpc = model_next(mpc, j, z, off);
      chk({tag, "_nreq"},  {31'd0, imem_req}, 32'd1);
      chk({tag, "_naddr"}, {16'd0, imem_addr}, mpc);
    end
  endtask

  task automatic restart(input string tag);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_idlereq"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_idlevld"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_idlehlt"}, {31'd0, halted}, 32'd0);
    chk({tag, "_idlepc"},  {16'd0, pc}, 32'd0);
    chk({tag, "_idleret"}, {16'd0, retire_cnt}, mret);
    start = 1'b1;
    mpc   = 0;
  endtask

  task automatic abort_fetch(input string tag);
    wait_req(tag);
    imem_ack = 1'b1; imem_data = 16'($urandom);
    start    = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk({tag, "_abvld"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_abreq"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_abpc"},  {16'd0, pc}, 32'd0);
    chk({tag, "_abret"}, {16'd0, retire_cnt}, mret);
    start = 1'b1;
    mpc   = 0;
  endtask

  task automatic halt_hold(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_hhalt"}, {31'd0, halted}, 32'd1);
      chk({tag, "_hreq"},  {31'd0, imem_req}, 32'd0);
      chk({tag, "_hpc"},   {16'd0, pc}, mpc);
    end
    restart(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    jump = 1'b0; zero = 1'b0; halt = 1'b0; imem_data = '0; offset = '0;
    repeat (2) @(negedge clk);
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_vld",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  {16'd0, instr}, 32'd0);
    chk("rst_pc",     {16'd0, pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_noreq", {31'd0, imem_req}, 32'd0);
    start = 1'b1;

    // Reset/start and sequential fetches
    fetch("t1", 16'hA001, 2);
    exec("t2a", 1'b0, 1'b0, 8'h00, 1'b0, 1);
    fetch("t2b", 16'hA002, 0);
    exec("t2b", 1'b0, 1'b1, 8'h55, 1'b0, 0);
    fetch("t2c", 16'hA003, 1);
    exec("t2c", 1'b1, 1'b0, 8'h33, 1'b0, 2);
    chk("t2_addr2", {16'd0, imem_addr}, 32'h0003);
    chk("t2_retire3", {16'd0, retire_cnt}, 32'd3);

    // Branches: reach 0x0010, taken -2, back to 0x0010, not-taken
    restart("t3");
    fetch("t3a", 16'h1111, 0); exec("t3a", 1'b1, 1'b1, 8'h10, 1'b0, 0);
    fetch("t3b", 16'h2222, 0); exec("t3b", 1'b1, 1'b1, 8'hFE, 1'b0, 0);
    chk("t3_taken", {16'd0, imem_addr}, 32'h000E);
    fetch("t3c", 16'h3333, 0); exec("t3c", 1'b1, 1'b1, 8'h02, 1'b0, 0);
    fetch("t3d", 16'h4444, 0); exec("t3d", 1'b1, 1'b0, 8'hFE, 1'b0, 0);
    chk("t3_nottaken", {16'd0, imem_addr}, 32'h0011);

    // Wrap both directions
    restart("t4");
    fetch("t4a", 16'h5555, 0); exec("t4a", 1'b1, 1'b1, 8'hFF, 1'b0, 0);
    chk("t4_ffff", {16'd0, imem_addr}, 32'hFFFF);
    fetch("t4b", 16'h6666, 0); exec("t4b", 1'b0, 1'b0, 8'h00, 1'b0, 0);
    chk("t4_wrap0", {16'd0, imem_addr}, 32'h0000);
    fetch("t4c", 16'h7777, 0); exec("t4c", 1'b1, 1'b1, 8'h02, 1'b0, 0);
    fetch("t4d", 16'h8888, 0); exec("t4d", 1'b1, 1'b1, 8'h80, 1'b0, 0);
    chk("t4_ff82", {16'd0, imem_addr}, 32'hFF82);

    // Halt wins over a taken jump
    fetch("t5", 16'h9999, 1);
    exec("t5", 1'b1, 1'b1, 8'h10, 1'b1, 0);
    halt_hold("t5");

    // Abort during fetch with simultaneous ack
    abort_fetch("t6a");

    // Async reset mid-EXEC and mid-FETCH
    fetch("t6b", 16'hBEEF, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vld",   {31'd0, instr_valid}, 32'd0);
    chk("t6_async_instr", {16'd0, instr}, 32'd0);
    chk("t6_async_ret",   {16'd0, retire_cnt}, 32'd0);
    chk("t6_async_pc",    {16'd0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mret = 0; mpc = 0;
    wait_req("t6c");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        abort_fetch("rnd_ab");
      end else begin
        fetch("rnd", 16'($urandom), int'($urandom_range(0, 3)));
        exec("rnd", 1'($urandom), 1'($urandom), 8'($urandom), (r >= 96),
             int'($urandom_range(0, 3)));
        if (r >= 96) halt_hold("rnd_h");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
